// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding, slice width
// and an index-width helper used to size the nibble counter.
package nibble_serial_adder_pkg;

    // Width of one arithmetic slice; the adder walks the operands in steps of this.
    localparam int unsigned SLICE_W = 4;

    // Controller states: waiting for operands, stepping through nibbles, holding a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_cla_4bits.sv
// Four-bit carry-lookahead slice. All carries are computed in parallel from
// the bit-level generate/propagate terms; group terms are offered for callers
// that chain slices hierarchically.
module cla_4bits
    import nibble_serial_adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout,
    output logic               grp_p,
    output logic               grp_g
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W:0]   c;

    // Bit-level generate and propagate.
    assign g = a & b;
    assign p = a ^ b;

    // Lookahead carries, each a flat sum of products of g/p and the carry-in.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[SLICE_W-1:0];
    assign cout = c[SLICE_W];

    // Group terms for hierarchical lookahead.
    assign grp_p = &p;
    assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: captures two W-bit operands, then adds one 4-bit
// nibble per cycle through a single CLA slice, rippling the carry through a
// register. The finished sum and its flags are held until the consumer takes
// them. Every output is either a register or a decode of the FSM state.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SLICE_W*NIBBLES-1:0] in_a,
    input  logic [SLICE_W*NIBBLES-1:0] in_b,
    input  logic                       in_cin,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SLICE_W*NIBBLES-1:0] out_sum,
    output logic                       out_cout,
    output logic                       out_ovf,
    output logic                       out_zero
);

    localparam int unsigned W     = SLICE_W * NIBBLES;
    localparam int unsigned IDX_W = idx_width(NIBBLES);

    // Operands and result are kept as nibble arrays so the running index
    // selects a whole slice directly.
    typedef logic [NIBBLES-1:0][SLICE_W-1:0] nib_vec_t;

    state_t     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic       carry_q, carry_d;
    nib_vec_t   a_q, a_d;
    nib_vec_t   b_q, b_d;
    nib_vec_t   sum_q, sum_d;
    logic       cout_q, cout_d;
    logic       ovf_q, ovf_d;
    logic       zero_q, zero_d;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               slice_grp_p;
    logic               slice_grp_g;
    logic               last_nibble;
    logic               carry_into_msb;
    logic               unused_grp;

    // Present the current nibble of each operand to the shared slice.
    assign slice_a     = a_q[idx_q];
    assign slice_b     = b_q[idx_q];
    assign last_nibble = (idx_q == IDX_W'(NIBBLES - 1));

    cla_4bits u_slice (
        .a     (slice_a),
        .b     (slice_b),
        .cin   (carry_q),
        .sum   (slice_sum),
        .cout  (slice_cout),
        .grp_p (slice_grp_p),
        .grp_g (slice_grp_g)
    );

    // The single slice is used serially, so its group terms have no consumer.
    assign unused_grp = slice_grp_p ^ slice_grp_g;

    // Carry into the top bit recovered from the top slice bit: s = a ^ b ^ c.
    assign carry_into_msb = slice_a[SLICE_W-1] ^ slice_b[SLICE_W-1]
                          ^ slice_sum[SLICE_W-1];

    // Next-state and datapath update for the controller.
    always_comb begin
        // NOTE: every _d starts as a copy of its _q so no path through this
        // block leaves a signal unassigned, which would infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q] = slice_sum;
                carry_d      = slice_cout;
                if (last_nibble) begin
                    // Index stays at its final value so it never wraps.
                    cout_d  = slice_cout;
                    ovf_d   = carry_into_msb ^ slice_cout;
                    zero_d  = (sum_d == '0);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                // Acceptance waits for IDLE, so a new operand lands one edge later.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            // NOTE: operand registers are reset too even though they are always
            // reloaded before use; it keeps the slice inputs free of X after reset.
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so all registers update from
            // the same pre-edge values, independent of statement order.
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = W'(sum_q);
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: expected results are queued as
// operands are driven and popped when the adder presents a result.
module tb_nibble_serial_adder;

    localparam int unsigned NIBBLES = 4;
    localparam int unsigned W       = 4 * NIBBLES;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } result_t;

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;

    result_t sb[$];
    int      n_checks = 0;
    int      n_errors = 0;

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference arithmetic on a W+1 bit sum; overflow from operand/result signs.
    function automatic result_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic cin);
        logic [W:0] full;
        result_t    r;
        full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (a[W-1] == b[W-1]) && (r.sum[W-1] != a[W-1]);
        r.zero = (r.sum == '0);
        return r;
    endfunction

    // Drive one operation, wait for the result, compare, hold it for `stall`
    // cycles, then consume. Called between clock edges.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input int stall);
        result_t exp;
        int      cyc;
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        sb.push_back(model(a, b, cin));
        @(posedge clk); #1;
        // Keep in_valid high with junk operands: the busy adder must ignore them.
        in_a   = ~a;
        in_b   = W'($urandom);
        in_cin = ~cin;
        check("in_ready_busy", 32'(in_ready), 32'd0);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 32'(cyc), 32'(NIBBLES));
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            exp = sb.pop_front();
            check("sum",  32'(out_sum),  32'(exp.sum));
            check("cout", 32'(out_cout), 32'(exp.cout));
            check("ovf",  32'(out_ovf),  32'(exp.ovf));
            check("zero", 32'(out_zero), 32'(exp.zero));
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                check("hold_sum",      32'(out_sum),   32'(exp.sum));
                check("hold_cout",     32'(out_cout),  32'(exp.cout));
                check("hold_valid",    32'(out_valid), 32'd1);
                check("hold_in_ready", 32'(in_ready),  32'd0);
            end
        end
        // Consume with in_valid still high: no acceptance may happen on this edge.
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("valid_cleared", 32'(out_valid), 32'd0);
        check("idle_after_consume", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        int seen_valid;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;

        #2;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(out_sum),   32'd0);
        check("rst_cout",      32'(out_cout),  32'd0);
        check("rst_ovf",       32'(out_ovf),   32'd0);
        check("rst_zero",      32'(out_zero),  32'd0);

        // Release between edges; the very next rising edge must accept.
        #10 reset_n = 1'b1;

        run_op(16'h1234, 16'h4321, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 0);
        run_op(16'h0000, 16'h0000, 1'b1, 0);
        // Backpressure, then a back-to-back operation right after the consume.
        run_op(16'h8000, 16'h8000, 1'b0, 3);
        run_op(16'h00FF, 16'h0F01, 1'b1, 0);

        // Reset in the middle of a run: the partial result must be discarded.
        in_a     = 16'hAAAA;
        in_b     = 16'h5555;
        in_cin   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        #1;
        check("midrun_rst_in_ready",  32'(in_ready),  32'd1);
        check("midrun_rst_out_valid", 32'(out_valid), 32'd0);
        check("midrun_rst_sum",       32'(out_sum),   32'd0);
        check("midrun_rst_cout",      32'(out_cout),  32'd0);
        check("midrun_rst_ovf",       32'(out_ovf),   32'd0);
        check("midrun_rst_zero",      32'(out_zero),  32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid++;
        end
        check("no_valid_after_abort", 32'(seen_valid), 32'd0);
        run_op(16'h0001, 16'h0001, 1'b0, 0);

        for (int i = 0; i < 6; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, operands present.
REQ-005 SHALL have port in_ready, output, 1, block can accept operands.
REQ-006 SHALL have ports in_a and in_b, input, W each, addends.
REQ-007 SHALL have port in_cin, input, 1, carry-in to nibble 0.
REQ-008 SHALL have port out_valid, output, 1, result present.
REQ-009 SHALL have port out_ready, input, 1, consumer takes result.
REQ-010 SHALL have port out_sum, output, W, registered sum.
REQ-011 SHALL have port out_cout, output, 1, carry out of the MSB.
REQ-012 SHALL have port out_ovf, output, 1, two's-complement overflow.
REQ-013 SHALL have port out_zero, output, 1, out_sum equals zero.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 in_ready SHALL be 1 exactly when state is IDLE.
REQ-016 In IDLE, in_valid=1 at a clock edge SHALL capture in_a, in_b and in_cin, clear the nibble index and move to RUN.
REQ-017 In RUN, each cycle SHALL add nibble[idx] of the captured operands plus the carry register through one 4-bit CLA slice.
REQ-018 In RUN, each cycle SHALL write the slice sum into out_sum[4*idx+3:4*idx], load the carry register from the slice carry-out, and increment idx.
REQ-019 In RUN, when idx = NIBBLES-1, the FSM SHALL move to DONE.
REQ-020 Latency: out_valid SHALL rise at the edge NIBBLES cycles after the accepting edge; with the default, 4 cycles later.
REQ-021 out_cout SHALL equal the carry-out of the last nibble.
REQ-022 out_ovf SHALL equal (carry into bit W-1) XOR (carry out of bit W-1).
REQ-023 out_zero SHALL be 1 iff all W bits of out_sum are 0.
REQ-024 out_cout, out_ovf and out_zero SHALL be valid whenever out_valid=1.
REQ-025 out_sum, out_cout, out_ovf and out_zero SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 In DONE, out_ready=1 at an edge SHALL clear out_valid and return to IDLE.
REQ-027 A new operand SHALL NOT be accepted in that same edge; the earliest new acceptance is the following edge.
REQ-028 In RUN and DONE, in_valid and operand inputs SHALL be ignored; captured operands SHALL NOT change.
REQ-029 idx SHALL be ceil(log2(NIBBLES)) bits wide (minimum 1).
REQ-030 idx SHALL never exceed NIBBLES-1; no wrap-around SHALL be observable.
REQ-031 The result SHALL be arithmetically exact modulo 2^W, with out_cout as bit W.

Reset
REQ-032 reset_n=0 SHALL, asynchronously and in any state including mid-RUN, force state IDLE, idx 0, carry register 0 and out_valid 0.
REQ-033 reset_n=0 SHALL also force out_sum 0, out_cout 0, out_ovf 0 and out_zero 0.
REQ-034 While reset_n=0, in_ready SHALL be 1 combinationally from the IDLE state.
REQ-035 An operation interrupted by reset SHALL be discarded; no partial result SHALL ever appear with out_valid=1.
REQ-036 The first acceptance SHALL be possible at the first rising edge after reset_n deasserts.

Structure
REQ-037 A shared package SHALL hold the FSM state encoding (IDLE, RUN, DONE) and the slice width constant 4.
REQ-038 The sole sub-module SHALL be the team's cla_4bits slice, instantiated once and reused every RUN cycle.
REQ-039 Slice group generate/propagate outputs SHALL be left unused.
REQ-040 The only combinational path from input to output SHALL be none; all outputs SHALL be registered or decoded from state.

Verification
REQ-041 0x1234 + 0x4321, cin=0 -> out_valid 4 cycles after accept; sum 0x5555, cout 0, ovf 0, zero 0.
REQ-042 0xFFFF + 0x0001, cin=0 -> sum 0x0000, cout 1, ovf 0, zero 1.
REQ-043 0x7FFF + 0x0001, cin=0 -> sum 0x8000, cout 0, ovf 1, zero 0.
REQ-044 0x0000 + 0x0000, cin=1 -> sum 0x0001, cout 0, ovf 0, zero 0.
REQ-045 Backpressure: out_ready held 0 for 3 cycles after out_valid; sum stays stable and in_ready stays 0.
REQ-046 Backpressure (cont.): out_ready=1 -> IDLE next edge; back-to-back operation accepted the edge after.
REQ-047 Reset mid-RUN: reset_n pulsed low after nibble 2 of 0xAAAA + 0x5555 -> all outputs 0, in_ready 1.
REQ-048 Reset mid-RUN (cont.): no out_valid pulse follows; the next operation 0x0001 + 0x0001 yields 0x0002.
